// File: rtl/rv32_pkg.sv
// Shared rv32 definitions: dext bus lane geometry and responder FSM states.
package rv32_pkg;

    localparam int unsigned DEXT_WAIT_W = 4;
    localparam int unsigned DEXT_LANES  = 4;
    localparam int unsigned DEXT_LANE_W = 8;
    localparam int unsigned DEXT_DATA_W = DEXT_LANES * DEXT_LANE_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dext_resp_state_e;

endpackage

// File: rtl/rv32_mod_dext_sram_responder_if.sv
// dext data-bus signal bundle; master is the load/store unit, slave the responder.
interface rv32_mod_dext_sram_responder_if;
    import rv32_pkg::*;

    logic                   dext_req;
    logic                   dext_wr;
    logic [DEXT_LANES-1:0]  dext_be;
    logic [31:0]            dext_addr;
    logic [DEXT_DATA_W-1:0] dext_do;
    logic                   dext_ack;
    logic                   dext_err;
    logic [DEXT_DATA_W-1:0] dext_di;

    modport master (
        output dext_req, dext_wr, dext_be, dext_addr, dext_do,
        input  dext_ack, dext_err, dext_di
    );

    modport slave (
        input  dext_req, dext_wr, dext_be, dext_addr, dext_do,
        output dext_ack, dext_err, dext_di
    );

endinterface

// File: rtl/rv32_mod_be_sram.sv
// Single-port byte-enabled synchronous SRAM, read-first, registered read data, no reset.
module rv32_mod_be_sram
    import rv32_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [DEXT_LANES-1:0]  be,
    input  logic [IDX_W-1:0]       idx,
    input  logic [DEXT_DATA_W-1:0] wdata,
    output logic [DEXT_DATA_W-1:0] rdata
);

    logic [DEXT_DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEXT_LANES; i++) begin
            if (we && be[i]) begin
                mem[idx][i*DEXT_LANE_W +: DEXT_LANE_W] <= wdata[i*DEXT_LANE_W +: DEXT_LANE_W];
            end
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/rv32_mod_dext_sram_responder.sv
// dext bus responder: one request at a time, configurable wait states, ack/err pulse,
// backed by a byte-enabled SRAM with an optional read-only low region.
module rv32_mod_dext_sram_responder
    import rv32_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned ROM_WORDS   = 0,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic                          clk,
    input logic                          reset,
    rv32_mod_dext_sram_responder_if.slave dext
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);
    localparam logic [DEXT_WAIT_W-1:0] WAIT_LOAD =
        (WAIT_STATES == 0) ? '0 : DEXT_WAIT_W'(WAIT_STATES - 1);

    dext_resp_state_e       state_q;
    logic [DEXT_WAIT_W-1:0] cnt_q;
    logic                   wr_q, bad_q, ack_q, err_q, rd_ack_q;
    logic [DEXT_LANES-1:0]  be_q;
    logic [IDX_W-1:0]       idx_q;
    logic [DEXT_DATA_W-1:0] wdata_q;

    logic [31:0]            offset;
    logic [IDX_W-1:0]       req_idx;
    logic                   req_bad;
    logic                   cur_wr, cur_bad, go_resp;
    logic [DEXT_LANES-1:0]  cur_be;
    logic [IDX_W-1:0]       cur_idx;
    logic [DEXT_DATA_W-1:0] cur_wdata, sram_rdata;

    // Offset wraps below BASE_ADDR, so one unsigned compare covers both bounds.
    assign offset  = dext.dext_addr - BASE_ADDR;
    assign req_idx = IDX_W'(offset >> 2);
    assign req_bad = (offset >= SPAN) || (dext.dext_be == '0) ||
                     (dext.dext_wr && (32'(req_idx) + 32'd1 <= ROM_WORDS));

    // In IDLE the SRAM sees the live request so a zero-wait access commits on acceptance.
    always_comb begin
        cur_wr    = wr_q;
        cur_be    = be_q;
        cur_idx   = idx_q;
        cur_wdata = wdata_q;
        cur_bad   = bad_q;
        if (state_q == IDLE) begin
            cur_wr    = dext.dext_wr;
            cur_be    = dext.dext_be;
            cur_idx   = req_idx;
            cur_wdata = dext.dext_do;
            cur_bad   = req_bad;
        end
    end

    assign go_resp = ((state_q == IDLE) && dext.dext_req && (WAIT_STATES == 0)) ||
                     ((state_q == WAIT) && (cnt_q == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rd_ack_q <= 1'b0;
            wr_q     <= 1'b0;
            bad_q    <= 1'b0;
            be_q     <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
        end else begin
            ack_q    <= go_resp && !cur_bad;
            err_q    <= go_resp && cur_bad;
            rd_ack_q <= go_resp && !cur_bad && !cur_wr;
            unique case (state_q)
                IDLE: begin
                    if (dext.dext_req) begin
                        wr_q    <= dext.dext_wr;
                        be_q    <= dext.dext_be;
                        idx_q   <= req_idx;
                        wdata_q <= dext.dext_do;
                        bad_q   <= req_bad;
                        if (go_resp) begin
                            state_q <= RESP;
                        end else begin
                            cnt_q   <= WAIT_LOAD;
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (go_resp) state_q <= RESP;
                    else         cnt_q   <= cnt_q - 1'b1;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    rv32_mod_be_sram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_sram (
        .clk  (clk),
        .we   (go_resp && cur_wr && !cur_bad),
        .be   (cur_be),
        .idx  (cur_idx),
        .wdata(cur_wdata),
        .rdata(sram_rdata)
    );

    assign dext.dext_ack = ack_q;
    assign dext.dext_err = err_q;
    assign dext.dext_di  = rd_ack_q ? sram_rdata : '0;

endmodule

// File: tb/tb_rv32_mod_dext_sram_responder.sv
// Randomized self-checking bench for the dext SRAM responder against a word-array model.
module tb_rv32_mod_dext_sram_responder;

    localparam int unsigned WS    = 3;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned ROM   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rv32_mod_dext_sram_responder_if dext ();

    rv32_mod_dext_sram_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (32'h0000_0000),
        .ROM_WORDS  (ROM),
        .WAIT_STATES(WS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .dext (dext)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: word contents plus which bytes are known (SRAM powers up undefined).
    logic [31:0] model_mem   [DEPTH];
    logic [3:0]  model_known [DEPTH];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic run_txn(input logic wr, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic drop);
        int          k;
        int          idx;
        logic        exp_err;
        logic [31:0] mask;
        idx     = int'(addr[31:2]) % DEPTH;
        exp_err = (addr >= 4 * DEPTH) || (be == 4'b0000) || (wr && idx < ROM);
        @(negedge clk);
        dext.dext_req  = 1'b1;
        dext.dext_wr   = wr;
        dext.dext_be   = be;
        dext.dext_addr = addr;
        dext.dext_do   = wdata;
        @(negedge clk);
        k = 1;
        if (drop) begin
            dext.dext_req  = 1'b0;
            dext.dext_wr   = 1'($urandom);
            dext.dext_be   = 4'($urandom);
            dext.dext_addr = $urandom;
            dext.dext_do   = $urandom;
        end
        while (!(dext.dext_ack || dext.dext_err) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_eq("latency", 32'(k), 32'(WS + 1));
        check_eq("ack", 32'(dext.dext_ack), 32'(!exp_err));
        check_eq("err", 32'(dext.dext_err), 32'(exp_err));
        if (exp_err || wr) begin
            check_eq("di_zero", dext.dext_di, 32'h0);
        end else begin
            mask = '0;
            for (int i = 0; i < 4; i++) if (model_known[idx][i]) mask[8*i +: 8] = 8'hFF;
            if (mask != '0) check_eq("rd_data", dext.dext_di & mask, model_mem[idx] & mask);
            model_mem[idx]   = (model_mem[idx] & mask) | (dext.dext_di & ~mask);
            model_known[idx] = 4'hF;
        end
        if (wr && !exp_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) model_mem[idx][8*i +: 8] = wdata[8*i +: 8];
            end
            model_known[idx] = model_known[idx] | be;
        end
        dext.dext_req = 1'b0;
        @(negedge clk);
        check_eq("pulse_len", 32'({dext.dext_ack, dext.dext_err}), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [31:0] addr;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]   = '0;
            model_known[i] = '0;
        end
        dext.dext_req  = 1'b0;
        dext.dext_wr   = 1'b0;
        dext.dext_be   = '0;
        dext.dext_addr = '0;
        dext.dext_do   = '0;
        reset          = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_ack", 32'(dext.dext_ack), 32'h0);
        check_eq("rst_err", 32'(dext.dext_err), 32'h0);
        check_eq("rst_di", dext.dext_di, 32'h0);
        reset = 1'b0;

        // Fill every writable word so most later reads have a known answer.
        for (int i = ROM; i < DEPTH; i++) run_txn(1'b1, 4'hF, 32'(4 * i), $urandom, 1'b0);

        run_txn(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0);
        run_txn(1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
        run_txn(1'b1, 4'hF, 32'h18, 32'h1122_3344, 1'b0);
        run_txn(1'b1, 4'b0101, 32'h18, 32'hAABB_CCDD, 1'b0);
        run_txn(1'b0, 4'b0010, 32'h1B, 32'h0, 1'b0);
        check_eq("lane_merge", model_mem[6], 32'h11BB_33DD);

        run_txn(1'b0, 4'hF, 32'h40, 32'h0, 1'b0);
        run_txn(1'b0, 4'h0, 32'h20, 32'h0, 1'b0);
        run_txn(1'b0, 4'hF, 32'h4, 32'h0, 1'b0);
        run_txn(1'b1, 4'hF, 32'h4, 32'h5555_AAAA, 1'b0);
        run_txn(1'b0, 4'hF, 32'h4, 32'h0, 1'b0);
        run_txn(1'b1, 4'h0, 32'h24, 32'h1234_5678, 1'b0);
        run_txn(1'b0, 4'hF, 32'h24, 32'h0, 1'b0);

        // Request held high across two transactions: acks spaced WS+2 apart.
        @(negedge clk);
        dext.dext_req  = 1'b1;
        dext.dext_wr   = 1'b0;
        dext.dext_be   = 4'hF;
        dext.dext_addr = 32'h10;
        @(negedge clk);
        k = 1;
        while (!dext.dext_ack && k < 20) begin @(negedge clk); k++; end
        check_eq("b2b_first_lat", 32'(k), 32'(WS + 1));
        @(negedge clk);
        check_eq("b2b_pulse", 32'(dext.dext_ack), 32'h0);
        k = 1;
        while (!dext.dext_ack && k < 20) begin @(negedge clk); k++; end
        check_eq("b2b_interval", 32'(k), 32'(WS + 2));
        check_eq("b2b_data", dext.dext_di, model_mem[4]);
        dext.dext_req = 1'b0;
        @(negedge clk);

        // Request dropped and inputs scrambled during WAIT: captured write still lands.
        run_txn(1'b1, 4'hF, 32'h20, 32'h0F0F_1234, 1'b1);
        run_txn(1'b0, 4'hF, 32'h20, 32'h0, 1'b0);

        // Reset two cycles into a write: no response, no commit.
        @(negedge clk);
        dext.dext_req  = 1'b1;
        dext.dext_wr   = 1'b1;
        dext.dext_be   = 4'hF;
        dext.dext_addr = 32'h14;
        dext.dext_do   = 32'hCAFE_F00D;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rst_wait_flags", 32'({dext.dext_ack, dext.dext_err}), 32'h0);
        check_eq("rst_wait_di", dext.dext_di, 32'h0);
        dext.dext_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < WS + 3; i++) begin
            @(negedge clk);
            check_eq("rst_no_pulse", 32'({dext.dext_ack, dext.dext_err}), 32'h0);
        end
        run_txn(1'b0, 4'hF, 32'h14, 32'h0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) != 0) addr = $urandom_range(0, 32'h4F);
            else addr = $urandom;
            run_txn(1'($urandom), 4'($urandom_range(0, 15)), addr, $urandom,
                    1'($urandom_range(0, 4) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rv32_mod_dext_sram_responder.md
# rv32_mod_dext_sram_responder

Responder (target) end of the `dext_*` data-bus protocol driven by `rv32_mod_load_store_unit`. It accepts one word-aligned request at a time, applies byte-enabled writes to or reads from an internal word-addressed SRAM, and completes each transaction with a single-cycle `ack` or `err` pulse after a configurable number of wait states. It serves as the default on-chip data memory for the rv32imc_ss core and as the bus model for LSU verification.

## Interface
- `DEPTH_WORDS`, 1024: SRAM size in 32-bit words; power of two, ≥ 2.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `4*DEPTH_WORDS`.
- `ROM_WORDS`, 0: words `[0, ROM_WORDS)` are read-only; 0 means none.
- `WAIT_STATES`, 0: extra cycles between acceptance and response; 0–15.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `dext_req` in 1: request valid; level, held by initiator until response.
- `dext_wr` in 1: 1 = write, 0 = read.
- `dext_be` in 4: byte-lane enables; bit n covers bits `[8n+7:8n]`.
- `dext_addr` in 32: byte address; bits `[1:0]` ignored.
- `dext_do` in 32: write data from initiator.
- `dext_ack` out 1: one-cycle success pulse.
- `dext_err` out 1: one-cycle error pulse; never asserted with `dext_ack`.
- `dext_di` out 32: read data; valid only while `dext_ack` is high on a read.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if `dext_req` is high, capture `wr`, `be`, word index, `do`, and the error decision. Go to RESP if `WAIT_STATES == 0`; otherwise load the wait counter with `WAIT_STATES-1` and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0, go to RESP. `dext_req` and the other inputs are ignored. A deassertion does not abort the transaction.
- RESP: drive `dext_ack` or `dext_err` high for exactly this cycle, then go to IDLE unconditionally. A request is never accepted in RESP, because the initiator still holds its old request during the ack cycle.
- The error decision is computed from the inputs at acceptance. `err` is raised for any of:
  - address outside `[BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS)`
  - `be == 4'b0000`
  - write with word index `< ROM_WORDS`
- An errored transaction does not modify memory and returns `dext_di = 0`.
- Write: on the clock edge that enters RESP, update only the lanes enabled by `be` with the matching lanes of the captured `do`. `dext_di = 0` during the ack cycle.
- Read: on the clock edge that enters RESP, register the full addressed word into `dext_di`, regardless of `be`. The initiator performs lane extraction and sign handling.
- Word index is `(addr - BASE_ADDR) >> 2`, truncated to `$clog2(DEPTH_WORDS)` bits.
- The SRAM array is not reset. Its contents are undefined after power-up, and `reset` leaves them unchanged.
- `dext_di` is 0 in every cycle except a read ack cycle.

## Timing
- Reset values: FSM = IDLE, counter = 0, `dext_ack = 0`, `dext_err = 0`, `dext_di = 0`.
- Latency: request accepted in cycle T; response in cycle `T+1+WAIT_STATES`.
- Maximum throughput: one transaction per `WAIT_STATES+2` cycles. The next acceptance is in `T+2+WAIT_STATES`, when `dext_req` is high again.
- A request already high when reset deasserts is accepted in the first IDLE cycle after reset.
- Reset during WAIT: the transaction is dropped, with no response. A pending write is not committed.
- Reset in RESP: the ack/err pulse is cleared immediately. A write already committed at RESP entry stays committed.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `rv32_pkg`:
  - `dext_resp_state_e` enum (IDLE, WAIT, RESP)
  - `DEXT_WAIT_W = 4` constant
  - the `dext_be` lane-width constants reused by the LSU
- One sub-module, `rv32_mod_be_sram`: single-port synchronous SRAM with inputs `we`, `be[3:0]`, `idx`, `wdata`, and a registered `rdata`. It has no reset.
- FSM, wait counter, address decode and error logic stay in the top module.

## Test plan
- Write then read, `WAIT_STATES=0`, `BASE_ADDR=0`:
  - Write `addr=0x10`, `be=4'b1111`, `do=0xDEADBEEF` gives `ack` at T+1 and `di=0`.
  - Read of `0x10` gives `ack` with `di=0xDEADBEEF`.
- Byte lanes:
  - Write `0x11223344` with `be=4'b1111`, then `0xAABBCCDD` with `be=4'b0101`.
  - Read back returns `0x11BB33DD`.
- Wait states, `WAIT_STATES=3`:
  - A read accepted in cycle T acks in T+4, with `ack` high for exactly 1 cycle.
  - `req` held high continuously is accepted again in T+5.
- Errors, `DEPTH_WORDS=16`, `ROM_WORDS=2`:
  - Read of `0x40` gives `err`.
  - Read with `be=0` gives `err`.
  - Write to `0x4` gives `err`, and a subsequent read of `0x4` returns the prior value.
- Reset mid-WAIT, `WAIT_STATES=5`:
  - Assert `reset` 2 cycles into a write of `0xCAFEF00D`.
  - Expect no ack/err pulse and all outputs 0.
  - A later read of that word returns the old value.
- `req` deasserted in WAIT:
  - The transaction still completes with `ack` at the scheduled cycle.
  - No new request is accepted until IDLE.
